// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM state,
// register-0 constant and the per-cycle stage control bundle.
package pipe_ctrl_pkg;

   localparam int          REG_W    = 5;
   localparam logic [4:0]  REG_ZERO = 5'd0;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } ctrl_state_e;

   // Enables and synchronous bubble inserts for PC and the four pipeline registers.
   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
      logic memwb_flush;
   } stage_ctrl_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter: counts cycles with inc_i high and sticks at all-ones.
module pipe_perf_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: memory-wait freeze, load-use bubble,
// redirect squash, performance counters and sticky memory-timeout flag.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_use_rs1_i,
   input  logic             id_use_rs2_i,
   input  logic [4:0]       idex_rd_i,
   input  logic             idex_is_load_i,
   input  logic             ex_redirect_i,
   input  logic             exmem_mem_op_i,
   input  logic             dmem_ack_i,
   output logic             dmem_req_o,
   output logic             pc_en_o,
   output logic             ifid_en_o,
   output logic             idex_en_o,
   output logic             exmem_en_o,
   output logic             memwb_en_o,
   output logic             ifid_flush_o,
   output logic             idex_flush_o,
   output logic             memwb_flush_o,
   output logic             mem_err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output ctrl_state_e      state_o
);

   localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

   ctrl_state_e   state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic          mem_err_q, mem_err_d;

   logic          timeout;
   logic          mstall;
   logic          load_use;
   logic          redirect_applied;
   stage_ctrl_t   ctrl;

   assign timeout = (state_q == MEM_WAIT) && (wait_q == WAIT_W'(MEM_TIMEOUT));
   assign mstall  = exmem_mem_op_i && !dmem_ack_i && !timeout;

   assign load_use = idex_is_load_i && (idex_rd_i != REG_ZERO) &&
                     ((id_use_rs1_i && (id_rs1_i == idex_rd_i)) ||
                      (id_use_rs2_i && (id_rs2_i == idex_rd_i)));

   // Held redirects and load-use hazards only take effect once the memory stall lifts.
   always_comb begin
      ctrl = '0;
      if (!rst_n) begin
         ctrl = '0;
      end else if (mstall) begin
         ctrl.memwb_flush = 1'b1;
      end else if (ex_redirect_i) begin
         ctrl.pc_en      = 1'b1;
         ctrl.ifid_en    = 1'b1;
         ctrl.idex_en    = 1'b1;
         ctrl.exmem_en   = 1'b1;
         ctrl.memwb_en   = 1'b1;
         ctrl.ifid_flush = 1'b1;
         ctrl.idex_flush = 1'b1;
      end else if (load_use) begin
         ctrl.idex_en    = 1'b1;
         ctrl.exmem_en   = 1'b1;
         ctrl.memwb_en   = 1'b1;
         ctrl.idex_flush = 1'b1;
      end else begin
         ctrl.pc_en    = 1'b1;
         ctrl.ifid_en  = 1'b1;
         ctrl.idex_en  = 1'b1;
         ctrl.exmem_en = 1'b1;
         ctrl.memwb_en = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      mem_err_d = mem_err_q;
      case (state_q)
         RUN: begin
            if (mstall) begin
               state_d = MEM_WAIT;
               wait_d  = '0;
            end
         end
         MEM_WAIT: begin
            if (mstall) begin
               wait_d = wait_q + WAIT_W'(1);
            end else begin
               state_d = RUN;
               // Only a release forced by the timeout (no real ack) is an error.
               if (timeout && exmem_mem_op_i && !dmem_ack_i) begin
                  mem_err_d = 1'b1;
               end
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RUN;
         wait_q    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         mem_err_q <= mem_err_d;
      end
   end

   assign redirect_applied = rst_n && !mstall && ex_redirect_i;

   pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (!ctrl.pc_en),
      .cnt_o (stall_cnt_o)
   );

   pipe_perf_cnt #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (redirect_applied),
      .cnt_o (flush_cnt_o)
   );

   assign dmem_req_o    = rst_n && exmem_mem_op_i;
   assign pc_en_o       = ctrl.pc_en;
   assign ifid_en_o     = ctrl.ifid_en;
   assign idex_en_o     = ctrl.idex_en;
   assign exmem_en_o    = ctrl.exmem_en;
   assign memwb_en_o    = ctrl.memwb_en;
   assign ifid_flush_o  = ctrl.ifid_flush;
   assign idex_flush_o  = ctrl.idex_flush;
   assign memwb_flush_o = ctrl.memwb_flush;
   assign mem_err_o     = mem_err_q;
   assign state_o       = state_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. It sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC: freezes on multi-cycle data-memory accesses, inserts a bubble on load-use hazards, and squashes wrong-path instructions on taken branches and jumps. It also keeps saturating stall/flush performance counters and a sticky memory-timeout error.

## Interface
- `CNT_W`, default 32: width of the performance counters.
- `MEM_TIMEOUT`, default 255: maximum MEM_WAIT cycles before the forced release; must be ≥1.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` in 1 each: the ID instruction reads rs1 / rs2.
- `idex_rd` in 5: destination register in ID/EX.
- `idex_is_load` in 1: the ID/EX instruction is a load.
- `ex_redirect` in 1: EX resolved a taken branch or jump (NPCOp not sequential).
- `exmem_mem_op` in 1: EX/MEM holds a load or store.
- `dmem_ack` in 1: data memory completes the current access this cycle.
- `dmem_req` out 1: data-memory request.
- `pc_en` out 1: PC register load enable.
- `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1 each: pipeline register enables.
- `ifid_flush`, `idex_flush`, `memwb_flush` out 1 each: synchronous bubble insert (zero all fields, including control). Flush overrides en in the register.
- `mem_err` out 1: sticky; set by a memory timeout.
- `stall_cnt` out CNT_W: count of cycles with `pc_en`=0.
- `flush_cnt` out CNT_W: count of applied redirects.

## Operation
- FSM, two states:
  - RUN: the pipeline advances unless a hazard applies.
  - MEM_WAIT: the pipeline is frozen pending `dmem_ack`.
- `dmem_req` = `exmem_mem_op` in both states, while `rst_n`=1.
- Memory-stall condition (mstall) = `exmem_mem_op` && !`dmem_ack` && !timeout.
- RUN with mstall:
  - all `*_en` = 0; `memwb_flush` = 1, so MEM/WB receives a bubble and no double writeback occurs;
  - next state is MEM_WAIT.
- MEM_WAIT:
  - identical outputs while mstall holds;
  - on `dmem_ack`: all enables = 1, `memwb_flush` = 0, next state RUN.
- Timeout:
  - the wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle;
  - when it reaches `MEM_TIMEOUT`, treat the cycle as an ack: advance, return to RUN and set `mem_err`;
  - `mem_err` clears only on reset.
- Priority when not memory-stalled: redirect > load-use > normal.
  - Redirect (`ex_redirect`=1): all enables = 1; `ifid_flush` = `idex_flush` = 1; `flush_cnt` += 1.
  - Load-use condition: `idex_is_load` && `idex_rd`≠0 && ((`id_use_rs1` && `id_rs1`==`idex_rd`) || (`id_use_rs2` && `id_rs2`==`idex_rd`)).
  - Load-use response: `pc_en` = `ifid_en` = 0; `idex_flush` = 1; `exmem_en` = `memwb_en` = 1.
  - Normal: all enables = 1, all flushes = 0.
- While memory-stalled, `ex_redirect` and load-use are held, not applied. They are evaluated in the release cycle, with the same priority.
- Counters: `stall_cnt` increments on every cycle with `pc_en`=0. Both counters saturate at all-ones.
- Outputs are combinational from state and inputs. While `rst_n`=0, all enables, flushes and `dmem_req` are forced to 0.

## Timing
- Reset: state RUN; wait counter 0; `mem_err` 0; `stall_cnt` 0; `flush_cnt` 0.
- Zero-wait memory (ack in the request cycle): no stall, and MEM_WAIT is never entered.
- Ack N cycles after the first request: the pipeline is frozen N cycles and `stall_cnt` increases by N.
- Load-use: 1-cycle stall, 1 bubble.
- Redirect: 2 bubbles (IF/ID and ID/EX), no stall cycle.
- Reset asserted mid-MEM_WAIT: immediate return to RUN; counters cleared.
- Back-to-back memory ops: each ack releases one; the next op re-enters MEM_WAIT on the following cycle if it is not acked.
- Ack with `exmem_mem_op`=0 is ignored.

## Structure
- `pipe_ctrl_pkg`:
  - FSM state enum {RUN, MEM_WAIT};
  - the register-0 constant;
  - a typedef for the stall/flush control bundle.
- Sub-module `pipe_perf_cnt`: a parameterised saturating counter, instantiated twice.
- Hazard comparison and priority logic stay inline.

## Test plan
- Load x5, then `add x6,x5,x1` in ID → one cycle with `pc_en`=0, `ifid_en`=0, `idex_flush`=1; `stall_cnt`=1.
- Load x0, then a user of x0 → no stall; all enables 1.
- `ex_redirect`=1 in RUN → `ifid_flush`=`idex_flush`=1, enables 1, `flush_cnt`=1, `stall_cnt` unchanged.
- Store with ack 3 cycles after the request → 3 frozen cycles with `memwb_flush`=1; release in cycle 4; `stall_cnt`=3.
- `ex_redirect` held during a 2-cycle MEM_WAIT → flushes only in the ack cycle; `flush_cnt` increments once.
- `MEM_TIMEOUT`=4, ack never arrives → forced release after 4 MEM_WAIT cycles and `mem_err`=1 until `rst_n` pulse; `rst_n` low mid-wait → state RUN and all outputs 0.
